// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a loadable right-shift register: one load cycle, then
// eff_amt single-bit shift cycles, then a one-cycle DONE that captures the result.
module shift_seq_ctrl #(
    parameter int W     = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic             cmd_type,
    output logic             shf_ld,
    output logic             shf_sh,
    output logic             shf_type,
    output logic [W-1:0]     shf_din,
    input  logic [W-1:0]     shf_dout,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] amt_q, amt_d;
    logic [W-1:0]     data_q, data_d;
    logic             type_q, type_d;
    logic [W-1:0]     result_q, result_d;

    logic             accept;

    // Shifting a W-bit value more than W places gives the same result as W places.
    function automatic logic [CNT_W-1:0] clamp_amt(input logic [CNT_W-1:0] a);
        if (int'(a) > W) begin
            return CNT_W'(W);
        end
        return a;
    endfunction

    assign accept = (state_q == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q  <= '0;
            amt_q    <= '0;
            data_q   <= '0;
            type_q   <= 1'b0;
            result_q <= '0;
        end else begin
            count_q  <= count_d;
            amt_q    <= amt_d;
            data_q   <= data_d;
            type_q   <= type_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (amt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (count_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command capture, shift countdown and result capture.
    always_comb begin
        count_d  = count_q;
        amt_d    = amt_q;
        data_d   = data_q;
        type_d   = type_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d = cmd_data;
                    type_d = cmd_type;
                    amt_d  = clamp_amt(cmd_amt);
                end
            end
            S_LOAD: begin
                count_d = amt_q;
            end
            S_SHIFT: begin
                count_d = count_q - CNT_W'(1);
            end
            S_DONE: begin
                if (!abort) begin
                    result_d = shf_dout;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Moore outputs: decoded from registered state and command only.
    always_comb begin
        shf_ld   = 1'b0;
        shf_sh   = 1'b0;
        shf_type = 1'b0;
        shf_din  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                shf_ld   = 1'b1;
                shf_type = type_q;
                shf_din  = data_q;
                busy     = 1'b1;
            end
            S_SHIFT: begin
                shf_sh   = 1'b1;
                shf_type = type_q;
                shf_din  = data_q;
                busy     = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign result = result_q;

endmodule
